// File: rtl/im_loader.sv
// rtl/im_loader.sv - copies a block of words from the disk unit into instruction memory
// One disk read, READ_LATENCY wait cycles, then one instruction-memory write per word.
module im_loader #(
  parameter int DATA_WIDTH      = 32,
  parameter int IM_ADDR_WIDTH   = 10,
  parameter int DISK_ADDR_WIDTH = 16,
  parameter int READ_LATENCY    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [DISK_ADDR_WIDTH-1:0] src_base,
  input  logic [IM_ADDR_WIDTH-1:0]   dst_base,
  input  logic [IM_ADDR_WIDTH:0]     length,
  output logic                       disk_rd,
  output logic [DISK_ADDR_WIDTH-1:0] disk_addr,
  input  logic [DATA_WIDTH-1:0]      disk_data,
  output logic                       im_write,
  output logic [IM_ADDR_WIDTH-1:0]   im_addr,
  output logic [DATA_WIDTH-1:0]      im_data,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam logic [2:0] LAT = 3'(READ_LATENCY);
  localparam logic [IM_ADDR_WIDTH+1:0] IM_SIZE = {2'b01, {IM_ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic [DISK_ADDR_WIDTH-1:0]   r_src;
  logic [IM_ADDR_WIDTH-1:0]     r_dst;
  logic [IM_ADDR_WIDTH:0]       r_len;
  logic [IM_ADDR_WIDTH:0]       r_idx;
  logic [2:0]                   r_lat;
  logic [DATA_WIDTH-1:0]        r_data;
  logic [DISK_ADDR_WIDTH-1:0]   r_disk_addr;
  logic [IM_ADDR_WIDTH-1:0]     r_im_addr;
  logic                         r_error;

  logic                         w_accept;
  logic                         w_disk_rd;
  logic                         w_im_write;
  logic                         w_capture;
  logic                         w_range_err;
  logic                         w_last;
  logic [IM_ADDR_WIDTH+1:0]     w_end;
  logic [IM_ADDR_WIDTH:0]       w_idx_inc;
  logic [DISK_ADDR_WIDTH-1:0]   w_disk_addr;
  logic [IM_ADDR_WIDTH-1:0]     w_im_addr;

  // Range check is widened by two bits so dst_base+length can never wrap.
  assign w_end       = {2'b00, dst_base} + {1'b0, length};
  assign w_range_err = (w_end > IM_SIZE);
  assign w_idx_inc   = r_idx + 1'b1;
  assign w_last      = (w_idx_inc == r_len);
  assign w_disk_addr = r_src + DISK_ADDR_WIDTH'(r_idx);
  assign w_im_addr   = r_dst + r_idx[IM_ADDR_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_disk_rd  = 1'b0;
    w_im_write = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (w_range_err || (length == '0)) w_next = S_DONE;
          else                                w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) w_next = S_IDLE;
        else begin
          w_disk_rd = 1'b1;
          w_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) w_next = S_IDLE;
        else if (r_lat == 3'd1) begin
          w_capture = 1'b1;
          w_next    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort) w_next = S_IDLE;
        else begin
          w_im_write = 1'b1;
          w_next     = w_last ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_lat       <= '0;
      r_data      <= '0;
      r_disk_addr <= '0;
      r_im_addr   <= '0;
      r_error     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_src   <= src_base;
        r_dst   <= dst_base;
        r_len   <= length;
        r_idx   <= '0;
        r_error <= w_range_err;
      end
      if (w_disk_rd) begin
        r_lat       <= LAT;
        r_disk_addr <= w_disk_addr;
      end
      if (r_state == S_WAIT) r_lat <= r_lat - 3'd1;
      if (w_capture) r_data <= disk_data;
      if (w_im_write) begin
        r_im_addr <= w_im_addr;
        r_idx     <= w_idx_inc;
      end
    end
  end

  // Address outputs show the live address during the strobe, else the last one used.
  assign disk_rd   = w_disk_rd;
  assign disk_addr = w_disk_rd ? w_disk_addr : r_disk_addr;
  assign im_write  = w_im_write;
  assign im_addr   = w_im_write ? w_im_addr : r_im_addr;
  assign im_data   = r_data;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign error     = r_error;

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - directed bench for im_loader at READ_LATENCY 1 and 3
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, sel = 1'b0;
  logic [15:0] src = '0;
  logic [9:0]  dst = '0;
  logic [10:0] len = '0;

  logic        rd0, rd1, wr0, wr1, bz0, bz1, dn0, dn1, er0, er1;
  logic [15:0] da0, da1;
  logic [31:0] dd0, dd1, id0, id1;
  logic [9:0]  ia0, ia1;
  logic [2:0]  dm0_cnt = '0, dm1_cnt = '0;
  logic [15:0] dm0_a = '0, dm1_a = '0;

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  im_loader #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel),
    .src_base(src), .dst_base(dst), .length(len),
    .disk_rd(rd0), .disk_addr(da0), .disk_data(dd0),
    .im_write(wr0), .im_addr(ia0), .im_data(id0),
    .busy(bz0), .done(dn0), .error(er0));

  im_loader #(.READ_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel),
    .src_base(src), .dst_base(dst), .length(len),
    .disk_rd(rd1), .disk_addr(da1), .disk_data(dd1),
    .im_write(wr1), .im_addr(ia1), .im_data(id1),
    .busy(bz1), .done(dn1), .error(er1));

  // Disk model: data is valid only in the last cycle of the read latency window.
  always @(posedge clk) begin
    if (rd0) begin dm0_cnt <= 3'd1; dm0_a <= da0; end
    else if (dm0_cnt != 3'd0) dm0_cnt <= dm0_cnt - 3'd1;
    if (rd1) begin dm1_cnt <= 3'd3; dm1_a <= da1; end
    else if (dm1_cnt != 3'd0) dm1_cnt <= dm1_cnt - 3'd1;
  end
  assign dd0 = (dm0_cnt == 3'd1) ? 32'hAAAA0000 + {16'h0, dm0_a} : 32'hDEADBEEF;
  assign dd1 = (dm1_cnt == 3'd1) ? 32'hAAAA0000 + {16'h0, dm1_a} : 32'hDEADBEEF;

  logic        m_rd, m_wr, m_bz, m_dn, m_er;
  logic [15:0] m_da;
  logic [9:0]  m_ia;
  logic [31:0] m_id;
  assign m_rd = sel ? rd1 : rd0;
  assign m_wr = sel ? wr1 : wr0;
  assign m_bz = sel ? bz1 : bz0;
  assign m_dn = sel ? dn1 : dn0;
  assign m_er = sel ? er1 : er0;
  assign m_da = sel ? da1 : da0;
  assign m_ia = sel ? ia1 : ia0;
  assign m_id = sel ? id1 : id0;

  int          rd_n, wr_n, done_n, done_c;
  logic        err_at_done;
  int          rd_c [2048];
  logic [15:0] rd_a [2048];
  int          wr_c [2048];
  logic [9:0]  wr_a [2048];
  logic [31:0] wr_d [2048];
  logic        busy_log [4096];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sample(input int k);
    if (m_rd && rd_n < 2048) begin rd_c[rd_n] = k; rd_a[rd_n] = m_da; rd_n++; end
    if (m_wr && wr_n < 2048) begin
      wr_c[wr_n] = k; wr_a[wr_n] = m_ia; wr_d[wr_n] = m_id; wr_n++;
    end
    if (m_dn) begin
      if (done_n == 0) begin done_c = k; err_at_done = m_er; end
      done_n++;
    end
    if (k < 4096) busy_log[k] = m_bz;
  endtask

  // Cycle 0 is the cycle in which start is sampled; outputs are sampled on the falling edge.
  task automatic run(input logic s, input logic [15:0] a_src, input logic [9:0] a_dst,
                     input logic [10:0] a_len, input int abort_cyc, input int ign_cyc,
                     input int ncyc);
    rd_n = 0; wr_n = 0; done_n = 0; done_c = -1; err_at_done = 1'bx;
    for (int i = 0; i < 2048; i++) begin
      rd_c[i] = -1; rd_a[i] = 16'hDEAD; wr_c[i] = -1; wr_a[i] = 10'h2AD; wr_d[i] = 32'hDEAD;
    end
    for (int i = 0; i < 4096; i++) busy_log[i] = 1'bx;
    sel = s;
    @(posedge clk); #1;
    src = a_src; dst = a_dst; len = a_len; start = 1'b1; abort = 1'b0;
    @(negedge clk); sample(0);
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      start = (k == ign_cyc);
      abort = (k == abort_cyc);
      if (k == ign_cyc) begin src = 16'h0500; dst = 10'h100; len = 11'd5; end
      @(negedge clk); sample(k);
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    int bad;
    int n_rd, n_wr, n_dn;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {bz0, bz1}, 2'b00);
    chk("rst_done", {dn0, dn1}, 2'b00);
    chk("rst_err",  {er0, er1}, 2'b00);
    chk("rst_strb", {rd0, rd1, wr0, wr1}, 4'b0000);
    chk("rst_addr", {da0, ia0, da1, ia1}, '0);
    chk("rst_data", {id0, id1}, '0);
    rst = 1'b0;

    run(1'b0, 16'h0100, 10'h010, 11'd2, -1, -1, 10);
    chk("basic_rd_n", rd_n, 2);
    chk("basic_rd0", {rd_c[0], 16'(rd_a[0])}, {32'd1, 16'h0100});
    chk("basic_rd1", {rd_c[1], 16'(rd_a[1])}, {32'd4, 16'h0101});
    chk("basic_wr_n", wr_n, 2);
    chk("basic_wr0", {wr_c[0], 16'(wr_a[0]), wr_d[0]}, {32'd3, 16'h0010, 32'hAAAA0100});
    chk("basic_wr1", {wr_c[1], 16'(wr_a[1]), wr_d[1]}, {32'd6, 16'h0011, 32'hAAAA0101});
    chk("basic_done", {done_n, done_c}, {32'd1, 32'd7});
    chk("basic_busy8", busy_log[8], 1'b0);
    chk("basic_hold", {m_da, 6'h0, m_ia}, {16'h0101, 16'h0011});

    run(1'b0, 16'h0000, 10'h005, 11'd0, -1, -1, 4);
    chk("zero_done", {done_n, done_c}, {32'd1, 32'd1});
    chk("zero_strb", {rd_n, wr_n}, 64'd0);
    chk("zero_err", err_at_done, 1'b0);

    run(1'b0, 16'h0000, 10'h3FE, 11'd3, -1, -1, 4);
    chk("rng_done", {done_n, done_c, 31'd0, err_at_done}, {32'd1, 32'd1, 32'd1});
    chk("rng_strb", {rd_n, wr_n}, 64'd0);
    chk("rng_sticky", m_er, 1'b1);
    run(1'b0, 16'h0010, 10'h3FE, 11'd2, -1, -1, 9);
    chk("rng_clear", {done_c, 31'd0, err_at_done}, {32'd7, 32'd0});
    chk("rng_edge_wr", {wr_n, 16'(wr_a[1]), wr_d[1]}, {32'd2, 16'h03FF, 32'hAAAA0011});

    run(1'b0, 16'h0200, 10'h020, 11'd4, 6, -1, 20);
    chk("abort_wr", {wr_n, 16'(wr_a[0])}, {32'd1, 16'h0020});
    chk("abort_rd", rd_n, 2);
    chk("abort_idle", busy_log[7], 1'b0);
    chk("abort_nodone", done_n, 0);

    run(1'b1, 16'h0300, 10'h040, 11'd1, -1, 2, 12);
    chk("lat3_done", {done_n, done_c}, {32'd1, 32'd6});
    chk("lat3_rd", {rd_n, rd_c[0], 16'(rd_a[0])}, {32'd1, 32'd1, 16'h0300});
    chk("lat3_wr", {wr_n, wr_c[0], 16'(wr_a[0]), wr_d[0]},
        {32'd1, 32'd5, 16'h0040, 32'hAAAA0300});

    sel = 1'b1;
    @(posedge clk); #1;
    src = 16'h0300; dst = 10'h040; len = 11'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", bz1, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {bz1, dn1, er1, rd1, wr1}, 5'b00000);
    chk("mid_rst_val", {da1, ia1, id1}, '0);
    @(posedge clk); #1; rst = 1'b0;
    n_rd = 0; n_wr = 0; n_dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rd1) n_rd++;
      if (wr1) n_wr++;
      if (dn1) n_dn++;
    end
    chk("mid_rst_quiet", {n_rd, n_wr, n_dn}, 96'd0);

    run(1'b0, 16'h0000, 10'h000, 11'd1024, -1, -1, 3080);
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (wr_a[i] !== 10'(i) || wr_d[i] !== 32'hAAAA0000 + 32'(i) || wr_c[i] != 3 + 3 * i)
        bad++;
    chk("fill_wr_n", wr_n, 1024);
    chk("fill_words", bad, 0);
    chk("fill_done", {done_n, done_c, 31'd0, err_at_done}, {32'd1, 32'd3073, 32'd0});
    chk("fill_busy", busy_log[3074], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
